// File: rtl/async_fifo_wr_arbiter.sv
// rtl/async_fifo_wr_arbiter.sv - round-robin burst arbiter for an async FIFO write port
//
// Purpose: NUM_REQ requesters share one FIFO write port. In IDLE the next owner is
// picked round-robin starting after the previous owner; in GRANT the owner streams
// beats until its burst ends, then the arbiter returns to IDLE for one cycle.
//
// Ports:
//   wr_clk, wr_rst_n    write-domain clock, asynchronous active-low reset
//   req_valid/req_last  per-requester beat valid and last-beat flags
//   req_data            packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready           per-requester beat accepted this cycle
//   fifo_wr_full        FIFO write-side full flag
//   fifo_wr_en          FIFO write enable
//   fifo_wr_data        {grant_id, payload}
//   grant_id            current owner index
//   busy                high while a requester owns the port
//
// Configuration macro: ASYNC_FIFO_WR_ARB_BURST_LOCK_EN
//   defined   - grant held until req_last or MAX_BURST beats
//   undefined - every beat ends the burst (per-beat round-robin)
module async_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_wr_full,
  output logic                          fifo_wr_en,
  output logic [IDW+DATA_WIDTH-1:0]     fifo_wr_data,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Reset value of last_gnt makes the first search start at requester 0.
  localparam logic [IDW-1:0] LAST_GNT_RST = IDW'(NUM_REQ - 1);

  state_e                state_q, state_d;
  logic [IDW-1:0]        grant_id_q, grant_id_d;
  logic [IDW-1:0]        last_gnt_q, last_gnt_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0]        rr_pick;
  logic [IDW-1:0]        rr_cand;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  xfer;
  logic                  burst_end;

  assign busy         = (state_q == GRANT);
  assign grant_id     = grant_id_q;
  assign owner_data   = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign xfer         = busy & req_valid[grant_id_q] & ~fifo_wr_full;
  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = {grant_id_q, owner_data};

  always_comb begin
    req_ready = '0;
    if (busy) begin
      req_ready[grant_id_q] = ~fifo_wr_full;
    end
  end

`ifdef ASYNC_FIFO_WR_ARB_BURST_LOCK_EN
  localparam logic [8:0] MAX_BURST_W = 9'(MAX_BURST);
  // 9-bit compare so MAX_BURST=256 is reachable from an 8-bit counter.
  assign burst_end = xfer & (req_last[grant_id_q] |
                             (({1'b0, beat_cnt_q} + 9'd1) == MAX_BURST_W));
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last;
  assign burst_end = xfer;
`endif

  // Scan offsets from NUM_REQ down to 1 so the smallest offset after last_gnt wins.
  always_comb begin
    rr_pick = last_gnt_q;
    rr_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_cand = IDW'((int'(last_gnt_q) + k) % NUM_REQ);
      if (req_valid[rr_cand]) begin
        rr_pick = rr_cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d    = GRANT;
          grant_id_d = rr_pick;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        if (burst_end) begin
          state_d    = IDLE;
          last_gnt_d = grant_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_gnt_q <= LAST_GNT_RST;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// tb/tb_async_fifo_wr_arbiter.sv - scoreboard bench for async_fifo_wr_arbiter
module tb_async_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 8;
  localparam int IDW        = $clog2(NUM_REQ);
`ifdef ASYNC_FIFO_WR_ARB_BURST_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic                          wr_clk;
  logic                          wr_rst_n;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_full;
  logic                          fifo_wr_en;
  logic [IDW+DATA_WIDTH-1:0]     fifo_wr_data;
  logic [IDW-1:0]                grant_id;
  logic                          busy;

  async_fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_wr_full(fifo_wr_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic [NUM_REQ-1:0] ready;
    logic               busy;
    logic               en;
    logic [IDW-1:0]     gid;
  } cyc_t;

  cyc_t                      cyc_q[$];
  logic [IDW+DATA_WIDTH-1:0] beat_q[$];
  int                        id_log[$];
  logic [DATA_WIDTH:0]       bq[NUM_REQ][$];   // {last, data} per requester

  int checks;
  int errors;

  // stimulus knobs
  logic [NUM_REQ-1:0] en_mask;
  int gap_pct, full_pct, fixed_len;
  bit force_full, no_last;

  // reference model: who owns the port next cycle, previous owner, beats in burst
  int m_owner, m_last, m_beats, m_xfers, pend_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_last   = NUM_REQ - 1;
    m_beats  = 0;
    pend_pop = -1;
  endtask

  task automatic gen_burst(input int i);
    int len;
    len = no_last ? 20 : ((fixed_len > 0) ? fixed_len : int'($urandom_range(1, 12)));
    for (int b = 0; b < len; b++) begin
      bq[i].push_back({(!no_last && b == len - 1), DATA_WIDTH'($urandom)});
    end
  endtask

  task automatic drive_cycle();
    logic [NUM_REQ-1:0] v;
    logic               full;
    logic [DATA_WIDTH:0] head;
    cyc_t               rec;
    int                 nxt;
    int                 j;
    @(negedge wr_clk);
    if (pend_pop >= 0) begin
      void'(bq[pend_pop].pop_front());
      pend_pop = -1;
    end
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en_mask[i] && bq[i].size() == 0) gen_burst(i);
      v[i] = en_mask[i] && (bq[i].size() > 0) && ($urandom_range(99) >= gap_pct);
      head = (bq[i].size() > 0) ? bq[i][0] : '0;
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];
      req_last[i] = head[DATA_WIDTH];
    end
    full = force_full || ($urandom_range(99) < full_pct);
    req_valid    = v;
    fifo_wr_full = full;

    rec.ready = '0;
    rec.busy  = (m_owner >= 0);
    rec.en    = 1'b0;
    rec.gid   = (m_owner >= 0) ? IDW'(m_owner) : '0;
    nxt = m_owner;
    if (m_owner < 0) begin
      if (v != '0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          j = (m_last + k) % NUM_REQ;
          if (v[j] && nxt < 0) nxt = j;
        end
        m_beats = 0;
      end
    end else begin
      rec.ready[m_owner] = !full;
      if (v[m_owner] && !full) begin
        head = bq[m_owner][0];
        rec.en = 1'b1;
        beat_q.push_back({IDW'(m_owner), head[DATA_WIDTH-1:0]});
        pend_pop = m_owner;
        m_beats++;
        m_xfers++;
        if (!LOCK || head[DATA_WIDTH] || m_beats == MAX_BURST) begin
          m_last = m_owner;
          nxt = -1;
        end
      end
    end
    cyc_q.push_back(rec);
    m_owner = nxt;
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    if (pend_pop >= 0) void'(bq[pend_pop].pop_front());
    wr_rst_n     = 1'b0;
    req_valid    = '0;
    fifo_wr_full = 1'b0;
    model_reset();
    for (int i = 0; i < NUM_REQ; i++) bq[i].delete();
    repeat (2) @(negedge wr_clk);
    wr_rst_n = 1'b1;
  endtask

  // monitor: compares whatever the DUT presents against the scoreboard queues
  initial begin
    cyc_t rec;
    logic [IDW+DATA_WIDTH-1:0] e;
    forever begin
      @(negedge wr_clk);
      #1;
      if (wr_rst_n && cyc_q.size() > 0) begin
        rec = cyc_q.pop_front();
        chk("req_ready", 64'(req_ready), 64'(rec.ready));
        chk("busy", 64'(busy), 64'(rec.busy));
        chk("fifo_wr_en", 64'(fifo_wr_en), 64'(rec.en));
        if (rec.busy) chk("grant_id", 64'(grant_id), 64'(rec.gid));
        if (fifo_wr_en) begin
          if (beat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none @%0t", fifo_wr_data, $time);
          end else begin
            e = beat_q.pop_front();
            chk("fifo_wr_data", 64'(fifo_wr_data), 64'(e));
          end
          id_log.push_back(int'(fifo_wr_data[IDW+DATA_WIDTH-1:DATA_WIDTH]));
        end
      end
    end
  end

  initial begin
    int n0, t, total;
    checks = 0;
    errors = 0;
    total  = 0;
    en_mask = '0; gap_pct = 0; full_pct = 0; fixed_len = 0;
    force_full = 1'b0; no_last = 1'b0; m_xfers = 0;
    model_reset();
    wr_rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; fifo_wr_full = 1'b0;
    repeat (2) @(negedge wr_clk);
    #1;
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fifo_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge wr_clk);
    wr_rst_n = 1'b1;

    // lone requester 2, 3-beat burst
    en_mask = 4'b0100; fixed_len = 3; id_log.delete();
    repeat (10) drive_cycle();
    #2;
    chk("a_beats", 64'(id_log.size() >= 3), 64'd1);
    for (int k = 0; k < 3 && k < id_log.size(); k++) chk("a_id", 64'(id_log[k]), 64'd2);

    // all four valid, 2-beat bursts
    do_reset();
    en_mask = 4'b1111; fixed_len = 2; id_log.delete();
    repeat (32) drive_cycle();
    #2;
    chk("b_beats", 64'(id_log.size() >= 10), 64'd1);
    for (int k = 0; k < 10 && k < id_log.size(); k++)
      chk("b_order", 64'(id_log[k]), 64'(LOCK ? (k / 2) % 4 : k % 4));

    // requesters 0 and 1 competing
    do_reset();
    en_mask = 4'b0011; fixed_len = 2; id_log.delete();
    repeat (20) drive_cycle();
    #2;
    for (int k = 0; k < 6 && k < id_log.size(); k++)
      chk("pair_order", 64'(id_log[k]), 64'(LOCK ? (k / 2) % 2 : k % 2));

    // requester 1 streaming without last, then requester 0 joins
    do_reset();
    en_mask = 4'b0010; no_last = 1'b1;
    repeat (30) drive_cycle();
    en_mask = 4'b0011;
    repeat (30) drive_cycle();
    no_last = 1'b0;

    // full held for 5 cycles mid-burst
    do_reset();
    en_mask = 4'b0001; fixed_len = 8; m_xfers = 0;
    for (t = 0; t < 50 && !(m_xfers >= 2 && m_owner >= 0); t++) drive_cycle();
    chk("d_wait_timeout", 64'(t < 50), 64'd1);
    #2;
    n0 = id_log.size();
    force_full = 1'b1;
    repeat (5) drive_cycle();
    #2;
    chk("d_stall_no_beats", 64'(id_log.size()), 64'(n0));
    force_full = 1'b0;
    repeat (12) drive_cycle();

    // asynchronous reset during beat 2 of requester 3
    do_reset();
    en_mask = 4'b1000; fixed_len = 4; m_xfers = 0;
    for (t = 0; t < 50 && !(m_xfers >= 1 && m_owner == 3); t++) drive_cycle();
    chk("e_wait_timeout", 64'(t < 50), 64'd1);
    drive_cycle();
    #3;
    wr_rst_n = 1'b0;
    #1;
    chk("e_rst_busy", 64'(busy), 64'd0);
    chk("e_rst_fifo_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("e_rst_req_ready", 64'(req_ready), 64'd0);
    chk("e_rst_grant_id", 64'(grant_id), 64'd0);
    req_valid = '0;
    model_reset();
    repeat (2) @(negedge wr_clk);
    wr_rst_n = 1'b1;
    en_mask = 4'b1010; fixed_len = 0; id_log.delete();
    repeat (10) drive_cycle();
    #2;
    chk("e_first_after_rst", 64'(id_log.size() > 0 ? id_log[0] : -1), 64'd1);

    // randomized traffic with gaps and full stalls
    do_reset();
    en_mask = 4'b1111; gap_pct = 30; full_pct = 20; fixed_len = 0; m_xfers = 0;
    repeat (500) drive_cycle();
    total = m_xfers;
    #2;
    chk("f_traffic", 64'(total > 100), 64'd1);
    chk("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
    chk("beat_q_drained", 64'(beat_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_arbiter.md
ASYNC_FIFO_WR_ARBITER -- requirements
Module: async_fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the FIFO write port, 2..16.
REQ-002 Parameter DATA_WIDTH, default 8: requester payload width.
REQ-003 Parameter MAX_BURST, default 8: maximum beats per grant, 1..256.
REQ-004 Derived IDW = $clog2(NUM_REQ): source-ID width.
REQ-005 wr_clk  in  1  write-domain clock, rising-edge.
REQ-006 wr_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  NUM_REQ  per-requester beat valid.
REQ-008 req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_last  in  NUM_REQ  per-requester last beat of burst.
REQ-010 req_ready  out  NUM_REQ  per-requester beat accepted this cycle.
REQ-011 fifo_wr_full  in  1  async FIFO write-side full flag.
REQ-012 fifo_wr_en  out  1  FIFO write enable.
REQ-013 fifo_wr_data  out  IDW+DATA_WIDTH  {grant_id, payload}.
REQ-014 grant_id  out  IDW  current owner index.
REQ-015 busy  out  1  high while in GRANT.

Function
REQ-016 FSM SHALL have two states, IDLE and GRANT.
REQ-017 IDLE: when any req_valid is high, the block SHALL select the first valid requester searching from (last_gnt+1) mod NUM_REQ upward with wrap, register it into grant_id, and enter GRANT on the next edge (1-cycle arbitration latency).
REQ-018 IDLE with no req_valid: SHALL remain in IDLE, grant_id unchanged.
REQ-019 GRANT: req_ready[grant_id] = ~fifo_wr_full; all other req_ready bits SHALL be 0; in IDLE all req_ready SHALL be 0.
REQ-020 fifo_wr_en SHALL equal busy & req_valid[grant_id] & ~fifo_wr_full (combinational); a beat is transferred when fifo_wr_en is high.
REQ-021 fifo_wr_data SHALL be {grant_id, req_data slice of grant_id}, combinational, valid whenever fifo_wr_en is high.
REQ-022 Beat counter (8 bits) SHALL clear on entry to GRANT and increment on each transferred beat; full stalls and valid-low cycles SHALL not change it.
REQ-023 Burst end: a transferred beat with req_last[grant_id]=1, or the transferred beat making the count equal MAX_BURST; on burst end the block SHALL set last_gnt=grant_id and return to IDLE on the next edge.
REQ-024 req_valid low on the owner during GRANT SHALL hold the grant with no timeout.
REQ-025 fifo_wr_full asserted mid-burst SHALL stall transfers without losing the grant; the burst resumes when full deasserts.
REQ-026 Requests from non-owners during GRANT SHALL be ignored until the next IDLE arbitration.
REQ-027 No requester SHALL be starved: with all requesters continuously valid, grant order SHALL be strictly 0,1,...,NUM_REQ-1,0,...

Reset
REQ-028 On wr_rst_n low (any time, asynchronously): state=IDLE, grant_id=0, last_gnt=NUM_REQ-1, beat counter=0, busy=0, req_ready=0, fifo_wr_en=0.
REQ-029 Reset mid-burst SHALL abandon the burst; beats already written remain in the FIFO; first post-reset grant goes to the lowest-indexed valid requester.

Configuration
REQ-030 Macro ASYNC_FIFO_WR_ARB_BURST_LOCK_EN: when defined, REQ-022/REQ-023 apply as written (grant held for multi-beat bursts).
REQ-031 When undefined, every transferred beat SHALL be a burst end (effective MAX_BURST=1, req_last ignored), giving per-beat round-robin interleaving.

Verification
REQ-032 Reset then req_valid=4'b0100, 3 beats, last on 3rd -> grant_id=2 one cycle later, three fifo_wr_en pulses with fifo_wr_data[top 2 bits]=2, busy drops after 3rd beat.
REQ-033 All four valid continuously, each burst 2 beats with last -> grant order 0,1,2,3,0; each burst 2 beats + 1 IDLE cycle.
REQ-034 MAX_BURST=8, requester 1 streams 20 beats without last (BURST_LOCK_EN defined) -> grant released after beat 8, requester 1 regranted only if no other valid, counter restarts.
REQ-035 fifo_wr_full held high for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 for those 5 cycles, beat count frozen, no data loss or duplication after release.
REQ-036 wr_rst_n pulsed low during beat 2 of requester 3's burst -> outputs immediately at reset values; after release, requesters 1 and 3 valid -> grant_id=1 first.
REQ-037 BURST_LOCK_EN undefined, requesters 0 and 1 valid continuously -> fifo_wr_data source IDs alternate 0,1,0,1.
